// File: rtl/detector_movimento_if.sv
// detector_movimento_if: button inputs, move pulse/direction and debug outputs of the move detector
interface detector_movimento_if;
  logic [3:0] botoes;
  logic       habilita;
  logic       borda_movimento;
  logic [1:0] direcao;
  logic [3:0] db_filtrado;
  logic [1:0] db_estado;
  modport master (output botoes, habilita, input borda_movimento, direcao, db_filtrado, db_estado);
  modport slave (input botoes, habilita, output borda_movimento, direcao, db_filtrado, db_estado);
endinterface

// File: rtl/detector_movimento.sv
// detector_movimento: synchronizes and debounces four buttons, emits one move pulse per press
module detector_movimento #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input logic clock,
  input logic reset,
  detector_movimento_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO = 2'b00, PULSO = 2'b01, AGUARDA_SOLTAR = 2'b10, INVALIDO = 2'b11} estado_t;
  localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CICLOS - 1);
  logic [3:0] sinc1, sinc2, filtrado, filtrado_ant, candidato;
  logic [15:0] cont [4];
  logic [1:0] direcao, direcao_prox, prioridade;
  estado_t estado, proximo;
  // candidates are registered so the FSM sees a filtered rise one cycle after it happens
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1 <= '0;
      sinc2 <= '0;
      filtrado <= '0;
      filtrado_ant <= '0;
      candidato <= '0;
      for (int i = 0; i < 4; i++) cont[i] <= '0;
      estado <= OCIOSO;
      direcao <= 2'b00;
    end else begin
      sinc1 <= bus.botoes;
      sinc2 <= sinc1;
      filtrado_ant <= filtrado;
      candidato <= filtrado & ~filtrado_ant;
      for (int i = 0; i < 4; i++) begin
        if (sinc2[i] == filtrado[i]) cont[i] <= '0;
        else if (cont[i] == LIMITE) begin
          cont[i] <= '0;
          filtrado[i] <= ~filtrado[i];
        end else cont[i] <= cont[i] + 16'd1;
      end
      estado <= proximo;
      direcao <= direcao_prox;
    end
  end
  always_comb begin
    prioridade = candidato[3] ? 2'b00 : candidato[2] ? 2'b01 : candidato[1] ? 2'b10 : 2'b11;
    proximo = (estado == OCIOSO) ? ((|candidato && bus.habilita) ? PULSO : OCIOSO) :
              (estado == PULSO) ? AGUARDA_SOLTAR :
              (estado == AGUARDA_SOLTAR && filtrado != 4'b0000) ? AGUARDA_SOLTAR : OCIOSO;
    direcao_prox = (estado == OCIOSO && proximo == PULSO) ? prioridade : direcao;
  end
  assign bus.borda_movimento = (estado == PULSO);
  assign bus.direcao = direcao;
  assign bus.db_filtrado = filtrado;
  assign bus.db_estado = estado;
endmodule

// File: tb/tb_detector_movimento.sv
// tb_detector_movimento: directed and random stimulus against a history-window reference model
module tb_detector_movimento;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  detector_movimento_if bus ();
  detector_movimento #(.DEBOUNCE_CICLOS(N)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int errors = 0, checks = 0;
  bit [3:0] raws[$], fs[$];
  bit mpulse, mwait;
  bit [1:0] mdir;
  int seg_k, pulses, first_pulse;
  function automatic bit [3:0] raw_at(int k);
    return (k < 0) ? 4'd0 : raws[k];
  endfunction
  function automatic bit [3:0] f_at(int k);
    return (k < 0) ? 4'd0 : fs[k];
  endfunction
  function automatic bit [1:0] prio(bit [3:0] c);
    return c[3] ? 2'd0 : c[2] ? 2'd1 : c[1] ? 2'd2 : 2'd3;
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // filtered level flips once the synchronized input (raw delayed two edges) has disagreed for N edges
  task automatic tick();
    bit [3:0] b, prev, fk, r2, w;
    bit h, rs, all;
    int k;
    @(posedge clock);
    b = bus.botoes;
    h = bus.habilita;
    rs = reset;
    fk = '0;
    if (rs) begin
      raws.delete();
      fs.delete();
      mpulse = 0;
      mwait = 0;
      mdir = 0;
    end else begin
      k = raws.size();
      raws.push_back(b);
      prev = f_at(k - 1);
      fk = prev;
      for (int i = 0; i < 4; i++) begin
        all = 1;
        for (int j = 0; j < N; j++) begin
          w = raw_at(k - 2 - j);
          if (w[i] == prev[i]) all = 0;
        end
        if (all) fk[i] = ~prev[i];
      end
      fs.push_back(fk);
      r2 = f_at(k - 2) & ~f_at(k - 3);
      if (mpulse) begin
        mpulse = 0;
        mwait = 1;
      end else if (mwait) begin
        if (f_at(k - 1) == 4'd0) mwait = 0;
      end else if (h && |r2) begin
        mpulse = 1;
        mdir = prio(r2);
      end
    end
    #1;
    check("borda", bus.borda_movimento, mpulse);
    check("direcao", bus.direcao, mdir);
    check("filtrado", bus.db_filtrado, fk);
    check("estado", bus.db_estado, {mwait, mpulse});
    if (bus.borda_movimento === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = seg_k;
    end
    seg_k++;
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic seg();
    seg_k = 0;
    pulses = 0;
    first_pulse = -1;
  endtask
  initial begin
    bus.botoes = 4'd0;
    bus.habilita = 1'b1;
    run(2);
    reset = 1'b0;
    run(3);
    seg();
    bus.botoes = 4'b0100;
    run(12);
    check("latency_edge", first_pulse, 7);
    check("latency_count", pulses, 1);
    check("latency_dir", bus.direcao, 2'b01);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.botoes = 4'b0100;
    run(3);
    bus.botoes = 4'd0;
    run(10);
    check("glitch_pulses", pulses, 0);
    seg();
    bus.botoes = 4'b1001;
    run(25);
    check("simul_count", pulses, 1);
    check("simul_dir", bus.direcao, 2'b00);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.botoes = 4'b0001;
    run(12);
    check("direita_edge", first_pulse, 7);
    check("direita_dir", bus.direcao, 2'b11);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.habilita = 1'b0;
    bus.botoes = 4'b0010;
    run(10);
    bus.habilita = 1'b1;
    run(15);
    check("held_enable_pulses", pulses, 0);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.botoes = 4'b0010;
    run(12);
    check("repress_edge", first_pulse, 7);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.botoes = 4'b0100;
    run(8);
    bus.habilita = 1'b0;
    run(1);
    bus.habilita = 1'b1;
    check("drop_enable_pulses", pulses, 1);
    bus.botoes = 4'd0;
    run(10);
    seg();
    bus.botoes = 4'b1000;
    run(6);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    check("reset_db", bus.db_filtrado, 4'd0);
    run(10);
    check("reset_edge", first_pulse, 14);
    check("reset_count", pulses, 1);
    bus.botoes = 4'd0;
    run(10);
    repeat (250) begin
      int r;
      r = $urandom_range(0, 9);
      bus.botoes = (r < 4) ? 4'd0 : (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      bus.habilita = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) == 0);
      run($urandom_range(1, 10));
      reset = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
